// File: rtl/multi_tick_divider_pkg.sv
// Shared types and constants for the multi_tick_divider block.
// Holds the config FSM state encoding and the board/simulation reset divisors.
package multi_tick_divider_pkg;

   typedef enum logic {
      CFG_IDLE,
      CFG_PEND
   } cfg_state_e;

   // 12 MHz board clock down to a 1 Hz tick.
   localparam int unsigned DEFAULT_DIV_BOARD = 32'd11999999;
   localparam int unsigned DEFAULT_DIV_SIM   = 32'd0;

endpackage

// File: rtl/multi_tick_divider_div_channel.sv
// One divider channel: phase counter, divisor register, tick/square/event outputs.
// The wrap event counter exists only when EVT_CNT_EN is defined; otherwise evt_o is 0.
module div_channel
   import multi_tick_divider_pkg::*;
#(
   parameter int unsigned      DIV_W       = 32,
   parameter int unsigned      CNT_W       = 4,
   parameter logic [DIV_W-1:0] DEFAULT_DIV = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             load_i,
   input  logic [DIV_W-1:0] load_div_i,
   output logic             wrap_o,
   output logic             tick_o,
   output logic             sq_o,
   output logic [CNT_W-1:0] evt_o
);

   logic [DIV_W-1:0] phase_q, phase_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             tick_q, tick_d;
   logic             sq_q, sq_d;

   assign wrap_o = en_i && (phase_q == div_q);

   // A load coinciding with a wrap still finishes this period on the old divisor.
   always_comb begin
      phase_d = phase_q;
      tick_d  = 1'b0;
      sq_d    = sq_q;
      div_d   = load_i ? load_div_i : div_q;
      if (!en_i) begin
         phase_d = '0;
      end else if (wrap_o) begin
         phase_d = '0;
         tick_d  = 1'b1;
         sq_d    = ~sq_q;
      end else begin
         phase_d = phase_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q <= '0;
         div_q   <= DEFAULT_DIV;
         tick_q  <= 1'b0;
         sq_q    <= 1'b0;
      end else begin
         phase_q <= phase_d;
         div_q   <= div_d;
         tick_q  <= tick_d;
         sq_q    <= sq_d;
      end
   end

   assign tick_o = tick_q;
   assign sq_o   = sq_q;

`ifdef EVT_CNT_EN
   logic [CNT_W-1:0] evt_q, evt_d;

   assign evt_d = wrap_o ? evt_q + CNT_W'(1) : evt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         evt_q <= '0;
      end else begin
         evt_q <= evt_d;
      end
   end

   assign evt_o = evt_q;
`else
   assign evt_o = '0;
`endif

endmodule

// File: rtl/multi_tick_divider.sv
// N-channel programmable tick divider with a single-slot divisor reload port.
// Per-channel wrap counters are built only when EVT_CNT_EN is defined.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   CFG_IDLE | slot free, cfg_ready high, accepting a request
//   CFG_PEND | request held, waiting for target channel wrap or disable
module multi_tick_divider
   import multi_tick_divider_pkg::*;
#(
   parameter  int unsigned NUM_CH      = 4,
   parameter  int unsigned DIV_W       = 32,
   parameter  int unsigned CNT_W       = 4,
   parameter  int unsigned DEFAULT_DIV = DEFAULT_DIV_BOARD,
   localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       en,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [CH_W-1:0]         cfg_chan,
   input  logic [DIV_W-1:0]        cfg_div,
   output logic                    cfg_err,
   output logic [NUM_CH-1:0]       tick,
   output logic [NUM_CH-1:0]       sq_out,
   output logic [NUM_CH*CNT_W-1:0] evt_cnt
);

   cfg_state_e        state_q, state_d;
   logic [CH_W-1:0]   pend_chan_q, pend_chan_d;
   logic [DIV_W-1:0]  pend_div_q, pend_div_d;
   logic              err_q, err_d;
   logic [NUM_CH-1:0] wrap;
   logic [NUM_CH-1:0] load;
   logic              chan_ok;

   assign chan_ok   = 32'(cfg_chan) < NUM_CH;
   assign cfg_ready = (state_q == CFG_IDLE);
   assign cfg_err   = err_q;

   always_comb begin
      state_d     = state_q;
      pend_chan_d = pend_chan_q;
      pend_div_d  = pend_div_q;
      err_d       = 1'b0;
      load        = '0;
      case (state_q)
         CFG_IDLE: begin
            if (cfg_valid) begin
               if (chan_ok) begin
                  pend_chan_d = cfg_chan;
                  pend_div_d  = cfg_div;
                  state_d     = CFG_PEND;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         CFG_PEND: begin
            // A disabled channel sits at phase 0, so loading it is always safe.
            for (int i = 0; i < NUM_CH; i++) begin
               if ((pend_chan_q == CH_W'(i)) && (wrap[i] || !en[i])) begin
                  load[i] = 1'b1;
               end
            end
            if (|load) begin
               state_d = CFG_IDLE;
            end
         end
         default: state_d = CFG_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= CFG_IDLE;
         pend_chan_q <= '0;
         pend_div_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_chan_q <= pend_chan_d;
         pend_div_q  <= pend_div_d;
         err_q       <= err_d;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      div_channel #(
         .DIV_W       (DIV_W),
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DIV_W'(DEFAULT_DIV))
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .en_i       (en[g]),
         .load_i     (load[g]),
         .load_div_i (pend_div_q),
         .wrap_o     (wrap[g]),
         .tick_o     (tick[g]),
         .sq_o       (sq_out[g]),
         .evt_o      (evt_cnt[g*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_multi_tick_divider.sv
// Self-checking bench for multi_tick_divider: directed scenarios plus a randomized
// run against an arithmetic reference model. Evt expectations follow EVT_CNT_EN.
module tb_multi_tick_divider;

   localparam int NUM_CH = 5;
   localparam int DIV_W  = 16;
   localparam int CNT_W  = 4;
   localparam int DEF    = 3;
   localparam int CH_W   = 3;

`ifdef EVT_CNT_EN
   localparam bit EVT_ON = 1'b1;
`else
   localparam bit EVT_ON = 1'b0;
`endif

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NUM_CH-1:0]       en;
   logic                    cfg_valid;
   logic                    cfg_ready;
   logic [CH_W-1:0]         cfg_chan;
   logic [DIV_W-1:0]        cfg_div;
   logic                    cfg_err;
   logic [NUM_CH-1:0]       tick;
   logic [NUM_CH-1:0]       sq_out;
   logic [NUM_CH*CNT_W-1:0] evt_cnt;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   multi_tick_divider #(
      .NUM_CH      (NUM_CH),
      .DIV_W       (DIV_W),
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEF)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_chan  (cfg_chan),
      .cfg_div   (cfg_div),
      .cfg_err   (cfg_err),
      .tick      (tick),
      .sq_out    (sq_out),
      .evt_cnt   (evt_cnt)
   );

   // Reference model: enabled-edge count since the period base, wrap when the
   // count is a multiple of (D+1); totals of wraps give sq and evt.
   int unsigned       m_div[NUM_CH];
   int unsigned       m_run[NUM_CH];
   int unsigned       m_wraps[NUM_CH];
   bit                m_wrapped[NUM_CH];
   logic [NUM_CH-1:0] m_tick;
   bit                m_pend, m_err;
   int unsigned       m_pchan, m_pdiv;

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_div[i] = DEF; m_run[i] = 0; m_wraps[i] = 0;
      end
      m_tick = '0; m_pend = 0; m_err = 0;
   endtask

   task automatic model_step();
      for (int i = 0; i < NUM_CH; i++) begin
         if (en[i]) begin
            m_run[i]++;
            m_wrapped[i] = (m_run[i] % (m_div[i] + 1)) == 0;
         end else begin
            m_run[i] = 0;
            m_wrapped[i] = 0;
         end
         m_tick[i] = m_wrapped[i];
         if (m_wrapped[i]) m_wraps[i]++;
      end
      m_err = 0;
      if (m_pend) begin
         if (m_wrapped[m_pchan] || !en[m_pchan]) begin
            m_div[m_pchan] = m_pdiv;
            m_run[m_pchan] = 0;
            m_pend = 0;
         end
      end else if (cfg_valid) begin
         if (int'(cfg_chan) < NUM_CH) begin
            m_pend = 1; m_pchan = cfg_chan; m_pdiv = cfg_div;
         end else begin
            m_err = 1;
         end
      end
   endtask

   task automatic test_reset();
      #3;
      checks++; if (tick !== '0) $display("FAIL reset_tick got %b exp 0", tick); else passed++;
      checks++; if (sq_out !== '0) $display("FAIL reset_sq got %b exp 0", sq_out); else passed++;
      checks++; if (evt_cnt !== '0) $display("FAIL reset_evt got %h exp 0", evt_cnt); else passed++;
      checks++; if (cfg_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", cfg_ready); else passed++;
      checks++; if (cfg_err !== 1'b0) $display("FAIL reset_err got %b exp 0", cfg_err); else passed++;
   endtask

   task automatic test_basic();
      logic [NUM_CH-1:0] exp_tick;
      logic [CNT_W-1:0]  exp_evt0;
      logic              exp_sq0;
      @(negedge clk);
      rst = 1'b0; en = 5'b00001;
      for (int e = 1; e <= 66; e++) begin
         @(negedge clk);
         exp_tick = (e % 4 == 0) ? 5'b00001 : 5'b00000;
         exp_sq0  = ((e / 4) % 2) == 1;
         exp_evt0 = EVT_ON ? CNT_W'((e / 4) % 16) : '0;
         checks++; if (tick !== exp_tick) $display("FAIL basic_tick e=%0d got %b exp %b", e, tick, exp_tick); else passed++;
         checks++; if (sq_out !== {4'b0, exp_sq0}) $display("FAIL basic_sq e=%0d got %b exp %b", e, sq_out, {4'b0, exp_sq0}); else passed++;
         checks++; if (evt_cnt !== {16'b0, exp_evt0}) $display("FAIL basic_evt e=%0d got %h exp %h", e, evt_cnt, {16'b0, exp_evt0}); else passed++;
      end
   endtask

   task automatic test_cfg_disabled();
      logic [CNT_W-1:0] exp_evt;
      cfg_valid = 1'b1; cfg_chan = 3'd1; cfg_div = 16'd0;
      @(negedge clk);
      checks++; if (cfg_ready !== 1'b0) $display("FAIL dis_ready_busy got %b exp 0", cfg_ready); else passed++;
      cfg_valid = 1'b0;
      @(negedge clk);
      checks++; if (cfg_ready !== 1'b1) $display("FAIL dis_ready_free got %b exp 1", cfg_ready); else passed++;
      en = 5'b00011;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         exp_evt = EVT_ON ? CNT_W'(k) : '0;
         checks++; if (tick[1] !== 1'b1) $display("FAIL dis_tick1 k=%0d got %b exp 1", k, tick[1]); else passed++;
         checks++; if (sq_out[1] !== k[0]) $display("FAIL dis_sq1 k=%0d got %b exp %b", k, sq_out[1], k[0]); else passed++;
         checks++; if (evt_cnt[CNT_W +: CNT_W] !== exp_evt) $display("FAIL dis_evt1 k=%0d got %h exp %h", k, evt_cnt[CNT_W +: CNT_W], exp_evt); else passed++;
      end
   endtask

   task automatic test_cfg_midperiod();
      // Channel 0 restarted so that phase=1 under divisor 3 when the request arrives.
      en = 5'b00010;
      @(negedge clk);
      en = 5'b00011;
      @(negedge clk);
      cfg_valid = 1'b1; cfg_chan = 3'd0; cfg_div = 16'd7;
      @(negedge clk);
      checks++; if (cfg_ready !== 1'b0) $display("FAIL mid_ready_n3 got %b exp 0", cfg_ready); else passed++;
      checks++; if (tick[0] !== 1'b0) $display("FAIL mid_tick_n3 got %b exp 0", tick[0]); else passed++;
      cfg_chan = 3'd2; cfg_div = 16'd5;
      @(negedge clk);
      checks++; if (cfg_ready !== 1'b0) $display("FAIL b2b_ready_n4 got %b exp 0", cfg_ready); else passed++;
      checks++; if (tick[0] !== 1'b0) $display("FAIL mid_tick_n4 got %b exp 0", tick[0]); else passed++;
      @(negedge clk);
      checks++; if (tick[0] !== 1'b1) $display("FAIL mid_tick_old_boundary got %b exp 1", tick[0]); else passed++;
      checks++; if (cfg_ready !== 1'b1) $display("FAIL mid_ready_after_apply got %b exp 1", cfg_ready); else passed++;
      @(negedge clk);
      checks++; if (cfg_ready !== 1'b0) $display("FAIL b2b_accepted got %b exp 0", cfg_ready); else passed++;
      cfg_valid = 1'b0;
      @(negedge clk);
      checks++; if (cfg_ready !== 1'b1) $display("FAIL b2b_applied got %b exp 1", cfg_ready); else passed++;
      for (int n = 8; n <= 22; n++) begin
         @(negedge clk);
         checks++;
         if (tick[0] !== ((n - 5) % 8 == 0)) $display("FAIL mid_tick_new n=%0d got %b exp %b", n, tick[0], (n - 5) % 8 == 0);
         else passed++;
      end
   endtask

   task automatic test_cfg_err();
      @(negedge clk);
      checks++; if (cfg_ready !== 1'b1) $display("FAIL err_ready_before got %b exp 1", cfg_ready); else passed++;
      cfg_valid = 1'b1; cfg_chan = 3'd5; cfg_div = 16'd1;
      @(negedge clk);
      checks++; if (cfg_err !== 1'b1) $display("FAIL err_pulse got %b exp 1", cfg_err); else passed++;
      checks++; if (cfg_ready !== 1'b1) $display("FAIL err_ready_stays got %b exp 1", cfg_ready); else passed++;
      cfg_valid = 1'b0;
      @(negedge clk);
      checks++; if (cfg_err !== 1'b0) $display("FAIL err_one_cycle got %b exp 0", cfg_err); else passed++;
      // Channel 0 keeps its 8-cycle period: last tick at n=21, next at n=29.
      for (int n = 26; n <= 29; n++) begin
         @(negedge clk);
         checks++;
         if (tick[0] !== (n == 29)) $display("FAIL err_no_div_change n=%0d got %b exp %b", n, tick[0], n == 29);
         else passed++;
      end
   endtask

   task automatic test_async_reset();
      logic [NUM_CH-1:0] exp_tick;
      cfg_valid = 1'b1; cfg_chan = 3'd0; cfg_div = 16'd1;
      @(negedge clk);
      cfg_valid = 1'b0;
      checks++; if (cfg_ready !== 1'b0) $display("FAIL arst_pending got %b exp 0", cfg_ready); else passed++;
      #2 rst = 1'b1;
      #1;
      checks++; if (tick !== '0) $display("FAIL arst_tick got %b exp 0", tick); else passed++;
      checks++; if (sq_out !== '0) $display("FAIL arst_sq got %b exp 0", sq_out); else passed++;
      checks++; if (evt_cnt !== '0) $display("FAIL arst_evt got %h exp 0", evt_cnt); else passed++;
      checks++; if (cfg_ready !== 1'b1) $display("FAIL arst_ready got %b exp 1", cfg_ready); else passed++;
      checks++; if (cfg_err !== 1'b0) $display("FAIL arst_err got %b exp 0", cfg_err); else passed++;
      @(negedge clk);
      rst = 1'b0; en = 5'b00001;
      for (int e = 1; e <= 12; e++) begin
         @(negedge clk);
         exp_tick = (e % 4 == 0) ? 5'b00001 : 5'b00000;
         checks++; if (tick !== exp_tick) $display("FAIL arst_discard e=%0d got %b exp %b", e, tick, exp_tick); else passed++;
      end
   endtask

   task automatic test_random();
      logic [NUM_CH-1:0]       exp_sq;
      logic [NUM_CH*CNT_W-1:0] exp_evt;
      rst = 1'b1; en = '0; cfg_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < NUM_CH; i++) en[i] = ($urandom_range(0, 7) != 0);
         cfg_valid = ($urandom_range(0, 3) == 0);
         cfg_chan  = CH_W'($urandom_range(0, 7));
         cfg_div   = DIV_W'($urandom_range(0, 6));
         @(negedge clk);
         model_step();
         for (int i = 0; i < NUM_CH; i++) begin
            exp_sq[i] = (m_wraps[i] % 2) == 1;
            exp_evt[i*CNT_W +: CNT_W] = EVT_ON ? CNT_W'(m_wraps[i] % 16) : '0;
         end
         checks++; if (tick !== m_tick) $display("FAIL rnd_tick c=%0d got %b exp %b", c, tick, m_tick); else passed++;
         checks++; if (sq_out !== exp_sq) $display("FAIL rnd_sq c=%0d got %b exp %b", c, sq_out, exp_sq); else passed++;
         checks++; if (evt_cnt !== exp_evt) $display("FAIL rnd_evt c=%0d got %h exp %h", c, evt_cnt, exp_evt); else passed++;
         checks++; if (cfg_ready !== !m_pend) $display("FAIL rnd_ready c=%0d got %b exp %b", c, cfg_ready, !m_pend); else passed++;
         checks++; if (cfg_err !== m_err) $display("FAIL rnd_err c=%0d got %b exp %b", c, cfg_err, m_err); else passed++;
      end
      cfg_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = '0; cfg_valid = 1'b0; cfg_chan = '0; cfg_div = '0;
      test_reset();
      test_basic();
      test_cfg_disabled();
      test_cfg_midperiod();
      test_cfg_err();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/multi_tick_divider.md
Name: multi_tick_divider

Overview:
- N-channel programmable divider, successor to the fixed single-counter divider.
- Each channel produces a one-cycle tick, a square wave, and an optional wrap event counter, all from one system clock.
- Divisors are reloaded at run time through a valid/ready config port; a change is applied glitch-free at the channel's next wrap.
- Feeds LED/display scanners, UART baud ticks and slow-strobe logic in the lab top level.

Parameters:
- NUM_CH, 4, number of independent channels (1..16)
- DIV_W, 32, width of each divisor and phase counter
- CNT_W, 4, width of each per-channel event counter
- DEFAULT_DIV, 11999999, divisor loaded into every channel at reset (period = DEFAULT_DIV+1)
- CH_W, $clog2(NUM_CH) min 1, width of cfg_chan (derived)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  NUM_CH  per-channel run enable
- cfg_valid  in  1  config request valid
- cfg_ready  out  1  config slot free
- cfg_chan  in  CH_W  target channel
- cfg_div  in  DIV_W  new divisor D (period D+1 cycles)
- cfg_err  out  1  one-cycle pulse: accepted request named a nonexistent channel
- tick  out  NUM_CH  one-cycle pulse per channel period
- sq_out  out  NUM_CH  toggles on each tick (period 2*(D+1))
- evt_cnt  out  NUM_CH*CNT_W  per-channel wrap count, channel i at bits [i*CNT_W +: CNT_W]

Behaviour:
- Clock and reset: reset is rst, asynchronous, active-high; clock is clk. All state is on posedge clk / posedge rst.
- Reset values: phase counters 0; div regs DEFAULT_DIV; tick 0; sq_out 0; evt_cnt 0; cfg_ready 1; cfg_err 0; pending slot empty.
- Channel i, on each edge:
  - en[i]=0: phase cleared to 0; tick[i] 0; sq_out/evt_cnt hold.
  - en[i]=1 and phase<div: phase+1; tick 0.
  - en[i]=1 and phase==div (wrap): phase to 0; tick[i]=1 for the next cycle; sq_out toggles; evt_cnt increments mod 2^CNT_W.
- Tick latency: tick is registered. From en rising (phase 0), first tick is high during cycle D+1 after the first enabled edge; afterwards one tick every D+1 cycles.
- D=0: tick high every cycle while enabled; sq_out toggles every cycle.
- Config FSM, single pending slot, states IDLE and PEND:
  - IDLE, cfg_ready=1: on cfg_valid&cfg_ready:
    - cfg_chan<NUM_CH: latch chan/div, go to PEND.
    - cfg_chan>=NUM_CH: request dropped, cfg_err=1 next cycle, stay IDLE.
  - PEND, cfg_ready=0: apply at the first edge where the target channel wraps, or where en[target]=0. div reg takes the new value and the FSM returns to IDLE; cfg_ready is 1 the following cycle.
- Wrap on the apply edge: the wrap completes normally with the old divisor (tick fires); the next period uses the new divisor.
- Phase above new divisor: cannot occur, since apply only happens at wrap or when disabled (phase=0).
- rst mid-operation: pending request discarded, all state returns to reset values immediately.

Optional Feature:
- Macro EVT_CNT_EN.
- Defined: evt_cnt counters are implemented as above.
- Undefined: no counter flops; evt_cnt tied to 0. tick, sq_out and config behaviour are unchanged.

Decomposition:
- Shared package holds:
  - config FSM state enum {CFG_IDLE, CFG_PEND}
  - DEFAULT_DIV constants for board (12 MHz → 1 Hz: 11999999) and simulation (0)
- One sub-module, div_channel: phase counter, div reg, tick/sq/evt logic, load strobe input. Instantiated NUM_CH times via generate; the config FSM stays in the top.

Test Plan:
- Reset, DEFAULT_DIV=3, en=4'b0001 → tick[0] every 4 cycles, sq_out[0] period 8, evt_cnt[0] counts 1,2,…,15,0. Other channels silent.
- cfg chan 1 div 0 while en[1]=0 → cfg_ready low one cycle, applied immediately. Then en[1]=1 → tick[1] every cycle.
- cfg chan 0 div 7 mid-period (phase 1, div 3) → next tick still at old boundary; following ticks spaced 8 cycles; cfg_ready low until that wrap.
- Second cfg_valid while PEND → not accepted (cfg_ready=0). Accepted the cycle after the apply.
- cfg_chan=5 with NUM_CH=4 → cfg_err pulse 1 cycle, no div change, cfg_ready stays 1.
- Assert rst while PEND and mid-count → all outputs 0 and cfg_ready 1 without a clock edge. After release, pending value is not applied.
